// File: rtl/id_decode_stage.sv
// Decode stage of the 16-bit pipelined CPU: decodes the fetched instruction into
// execute-stage controls, registers them into ID/EX, and resolves load-use hazards.
module id_decode_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    output logic        if_stall,
    input  logic        ex_stall,
    input  logic        flush,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    output logic        ex_valid,
    output logic [1:0]  ex_alu_a_sel,
    output logic [2:0]  ex_alu_b_sel,
    output logic [1:0]  ex_alu_op,
    output logic [7:0]  ex_imm8,
    output logic [10:0] ex_imm11,
    output logic [2:0]  ex_rx,
    output logic        ex_rf_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_jump,
    output logic [1:0]  ex_jcond,
    output logic        ex_call,
    output logic [15:0] ex_pc
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MVHI = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [1:0]  a_sel;
        logic [2:0]  b_sel;
        logic [1:0]  alu_op;
        logic [7:0]  imm8;
        logic [10:0] imm11;
        logic [2:0]  rx;
        logic        rf_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        jump;
        logic [1:0]  jcond;
        logic        call;
        logic [15:0] pc;
    } idex_t;

    logic [3:0] opcode;
    logic       imm_flag;
    logic [2:0] rx_field;
    logic [2:0] ry_field;

    assign opcode   = if_instr[3:0];
    assign imm_flag = if_instr[4];
    assign rx_field = if_instr[7:5];
    assign ry_field = if_instr[10:8];

    idex_t dec;
    idex_t bubble;
    idex_t idex_reg;
    idex_t idex_next;
    logic  use_a;
    logic  use_b;
    logic  b_is_rx;
    logic  hazard;

    always_comb begin
        dec        = '0;
        dec.imm8   = if_instr[15:8];
        dec.imm11  = if_instr[15:5];
        dec.rx     = rx_field;
        dec.pc     = if_pc;
        use_a      = 1'b0;
        b_is_rx    = 1'b0;
        case (opcode)
            4'd0: begin
                dec.valid  = 1'b1;
                dec.a_sel  = 2'd1;
                dec.b_sel  = imm_flag ? 3'd0 : 3'd1;
                dec.alu_op = OP_ADD;
                dec.rf_we  = 1'b1;
            end
            4'd1, 4'd2, 4'd3: begin
                dec.valid  = 1'b1;
                dec.a_sel  = 2'd0;
                dec.b_sel  = imm_flag ? 3'd0 : 3'd1;
                dec.alu_op = (opcode == 4'd1) ? OP_ADD : OP_SUB;
                dec.rf_we  = (opcode != 4'd3);
                use_a      = 1'b1;
            end
            4'd4: begin
                dec.valid  = 1'b1;
                dec.a_sel  = 2'd1;
                dec.b_sel  = 3'd1;
                dec.alu_op = OP_ADD;
                dec.rf_we  = 1'b1;
                dec.mem_rd = 1'b1;
            end
            4'd5: begin
                // Address Ry comes through port B; store data Rx through port A.
                dec.valid  = 1'b1;
                dec.a_sel  = 2'd1;
                dec.b_sel  = 3'd1;
                dec.alu_op = OP_ADD;
                dec.mem_wr = 1'b1;
                use_a      = 1'b1;
            end
            4'd6: begin
                dec.valid  = 1'b1;
                dec.a_sel  = 2'd3;
                dec.b_sel  = 3'd3;
                dec.alu_op = OP_MVHI;
                dec.rf_we  = 1'b1;
                use_a      = 1'b1;
            end
            4'd8, 4'd9, 4'd10, 4'd12: begin
                dec.valid  = 1'b1;
                dec.jump   = 1'b1;
                dec.alu_op = OP_ADD;
                if (imm_flag) begin
                    dec.a_sel = 2'd2;
                    dec.b_sel = 3'd2;
                end else begin
                    // Register-form target Rx is routed through port B.
                    dec.a_sel = 2'd1;
                    dec.b_sel = 3'd1;
                    b_is_rx   = 1'b1;
                end
                case (opcode)
                    4'd9:    dec.jcond = 2'd1;
                    4'd10:   dec.jcond = 2'd2;
                    default: dec.jcond = 2'd0;
                endcase
                if (opcode == 4'd12) begin
                    dec.call  = 1'b1;
                    dec.rx    = 3'd7;
                    dec.rf_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign use_b     = (dec.b_sel == 3'd1);
    assign rf_addr_a = rx_field;
    assign rf_addr_b = b_is_rx ? rx_field : ry_field;

    assign hazard = if_valid & idex_reg.valid & idex_reg.mem_rd &
                    ((use_a & (idex_reg.rx == rf_addr_a)) |
                     (use_b & (idex_reg.rx == rf_addr_b)));

    assign if_stall = reset_n & ~flush & (ex_stall | hazard);

    always_comb begin
        bubble        = dec;
        bubble.valid  = 1'b0;
        bubble.rf_we  = 1'b0;
        bubble.mem_rd = 1'b0;
        bubble.mem_wr = 1'b0;
        bubble.jump   = 1'b0;
        bubble.call   = 1'b0;
    end

    always_comb begin
        idex_next = idex_reg;
        if (flush)
            idex_next = bubble;
        else if (ex_stall)
            idex_next = idex_reg;
        else if (hazard || !if_valid)
            idex_next = bubble;
        else
            idex_next = dec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idex_reg <= '0;
        else
            idex_reg <= idex_next;
    end

    assign ex_valid     = idex_reg.valid;
    assign ex_alu_a_sel = idex_reg.a_sel;
    assign ex_alu_b_sel = idex_reg.b_sel;
    assign ex_alu_op    = idex_reg.alu_op;
    assign ex_imm8      = idex_reg.imm8;
    assign ex_imm11     = idex_reg.imm11;
    assign ex_rx        = idex_reg.rx;
    assign ex_rf_we     = idex_reg.rf_we;
    assign ex_mem_rd    = idex_reg.mem_rd;
    assign ex_mem_wr    = idex_reg.mem_wr;
    assign ex_jump      = idex_reg.jump;
    assign ex_jcond     = idex_reg.jcond;
    assign ex_call      = idex_reg.call;
    assign ex_pc        = idex_reg.pc;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: hand-computed decode, hazard, stall, flush
// and reset expectations.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_stall;
    logic        ex_stall;
    logic        flush;
    logic [2:0]  rf_addr_a;
    logic [2:0]  rf_addr_b;
    logic        ex_valid;
    logic [1:0]  ex_alu_a_sel;
    logic [2:0]  ex_alu_b_sel;
    logic [1:0]  ex_alu_op;
    logic [7:0]  ex_imm8;
    logic [10:0] ex_imm11;
    logic [2:0]  ex_rx;
    logic        ex_rf_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_jump;
    logic [1:0]  ex_jcond;
    logic        ex_call;
    logic [15:0] ex_pc;

    int checks = 0;
    int errors = 0;

    id_decode_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_stall     (if_stall),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .rf_addr_a    (rf_addr_a),
        .rf_addr_b    (rf_addr_b),
        .ex_valid     (ex_valid),
        .ex_alu_a_sel (ex_alu_a_sel),
        .ex_alu_b_sel (ex_alu_b_sel),
        .ex_alu_op    (ex_alu_op),
        .ex_imm8      (ex_imm8),
        .ex_imm11     (ex_imm11),
        .ex_rx        (ex_rx),
        .ex_rf_we     (ex_rf_we),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr),
        .ex_jump      (ex_jump),
        .ex_jcond     (ex_jcond),
        .ex_call      (ex_call),
        .ex_pc        (ex_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [15:0] instr, input logic [15:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        $display("txn instr=%04h pc=%04h", instr, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b1;
        if_valid = 1'b0;
        if_instr = 16'h0000;
        if_pc    = 16'h0000;
        ex_stall = 1'b1;
        flush    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", ex_valid, 0);
        check_eq("rst_pc", ex_pc, 0);
        check_eq("rst_we", ex_rf_we, 0);
        check_eq("rst_bsel", ex_alu_b_sel, 0);
        check_eq("rst_stall", if_stall, 0);
        tick();
        tick();
        ex_stall = 1'b0;
        reset_n  = 1'b1;

        // add R1,R2
        apply(16'h0221, 16'h0010);
        #1;
        check_eq("add_rfa", rf_addr_a, 1);
        check_eq("add_rfb", rf_addr_b, 2);
        tick();
        check_eq("add_valid", ex_valid, 1);
        check_eq("add_asel", ex_alu_a_sel, 0);
        check_eq("add_bsel", ex_alu_b_sel, 1);
        check_eq("add_op", ex_alu_op, 0);
        check_eq("add_rx", ex_rx, 1);
        check_eq("add_we", ex_rf_we, 1);
        check_eq("add_pc", ex_pc, 16'h0010);

        // addi R1,#5
        apply(16'h0531, 16'h0012);
        tick();
        check_eq("addi_bsel", ex_alu_b_sel, 0);
        check_eq("addi_imm8", ex_imm8, 8'h05);

        // mvhi R1,#0xAB
        apply(16'hAB36, 16'h0014);
        tick();
        check_eq("mvhi_asel", ex_alu_a_sel, 3);
        check_eq("mvhi_bsel", ex_alu_b_sel, 3);
        check_eq("mvhi_op", ex_alu_op, 2);
        check_eq("mvhi_imm8", ex_imm8, 8'hAB);

        // ld R3,[R2]; add R1,R3 (port B hazard); sub; cmp -> 5 edges
        apply(16'h0264, 16'h0020);
        tick();
        check_eq("ld_memrd", ex_mem_rd, 1);
        check_eq("ld_rx", ex_rx, 3);
        apply(16'h0321, 16'h0022);
        #1;
        check_eq("lu_stall", if_stall, 1);
        tick();
        check_eq("lu_bubble", ex_valid, 0);
        check_eq("lu_bubble_we", ex_rf_we, 0);
        #1;
        check_eq("lu_unstall", if_stall, 0);
        tick();
        check_eq("lu_add_valid", ex_valid, 1);
        check_eq("lu_add_pc", ex_pc, 16'h0022);
        apply(16'h0122, 16'h0024);
        tick();
        check_eq("sub_op", ex_alu_op, 1);
        check_eq("sub_we", ex_rf_we, 1);
        apply(16'h0123, 16'h0026);
        tick();
        check_eq("cmp_op", ex_alu_op, 1);
        check_eq("cmp_we", ex_rf_we, 0);
        check_eq("cmp_pc", ex_pc, 16'h0026);

        // ld R3 then st R3,[R4]: port A hazard
        apply(16'h0264, 16'h0030);
        tick();
        apply(16'h0465, 16'h0032);
        #1;
        check_eq("st_stall", if_stall, 1);
        tick();
        check_eq("st_bubble", ex_valid, 0);
        tick();
        check_eq("st_memwr", ex_mem_wr, 1);
        check_eq("st_we", ex_rf_we, 0);

        // ld R3 then addi R1,#3: no source matches
        apply(16'h0264, 16'h0040);
        tick();
        apply(16'h0331, 16'h0042);
        #1;
        check_eq("nohz_stall", if_stall, 0);
        tick();
        check_eq("nohz_valid", ex_valid, 1);
        check_eq("nohz_imm8", ex_imm8, 8'h03);

        // j imm11=0x7FE
        apply(16'hFFD8, 16'h0100);
        tick();
        check_eq("j_asel", ex_alu_a_sel, 2);
        check_eq("j_bsel", ex_alu_b_sel, 2);
        check_eq("j_jump", ex_jump, 1);
        check_eq("j_jcond", ex_jcond, 0);
        check_eq("j_imm11", ex_imm11, 11'h7FE);
        check_eq("j_we", ex_rf_we, 0);
        check_eq("j_pc", ex_pc, 16'h0100);

        // call (immediate form)
        apply(16'h001C, 16'h0102);
        tick();
        check_eq("call_rx", ex_rx, 7);
        check_eq("call_call", ex_call, 1);
        check_eq("call_we", ex_rf_we, 1);
        check_eq("call_jump", ex_jump, 1);

        // jz R2 (register form: target on port B)
        apply(16'h0049, 16'h0104);
        #1;
        check_eq("jzr_rfb", rf_addr_b, 2);
        tick();
        check_eq("jzr_asel", ex_alu_a_sel, 1);
        check_eq("jzr_bsel", ex_alu_b_sel, 1);
        check_eq("jzr_jcond", ex_jcond, 1);
        check_eq("jzr_we", ex_rf_we, 0);

        // flush + ex_stall with a hazard pending
        apply(16'h0264, 16'h0110);
        tick();
        apply(16'h0321, 16'h0112);
        flush    = 1'b1;
        ex_stall = 1'b1;
        #1;
        check_eq("fl_stall", if_stall, 0);
        tick();
        check_eq("fl_valid", ex_valid, 0);
        check_eq("fl_memrd", ex_mem_rd, 0);
        flush    = 1'b0;
        ex_stall = 1'b0;

        // ex_stall alone for three cycles
        apply(16'h0531, 16'h0200);
        tick();
        apply(16'h0221, 16'h0202);
        ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("hold_stall", if_stall, 1);
            tick();
            check_eq("hold_pc", ex_pc, 16'h0200);
            check_eq("hold_valid", ex_valid, 1);
            check_eq("hold_bsel", ex_alu_b_sel, 0);
        end
        ex_stall = 1'b0;
        tick();
        check_eq("rel_pc", ex_pc, 16'h0202);

        // undefined opcode 0xF
        apply(16'h000F, 16'h0210);
        tick();
        check_eq("opf_valid", ex_valid, 0);
        check_eq("opf_we", ex_rf_we, 0);
        check_eq("opf_jump", ex_jump, 0);

        // asynchronous reset mid-stream, then normal decode after release
        apply(16'h0221, 16'h0300);
        tick();
        check_eq("pre_rst_valid", ex_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", ex_valid, 0);
        check_eq("arst_pc", ex_pc, 0);
        check_eq("arst_we", ex_rf_we, 0);
        #1 reset_n = 1'b1;
        apply(16'h0221, 16'h0302);
        tick();
        check_eq("post_rst_valid", ex_valid, 1);
        check_eq("post_rst_pc", ex_pc, 16'h0302);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
